// File: rtl/logic_pkg.sv
// rtl/logic_pkg.sv - operation codes and per-bit operation helper for logic_unit_pipe
//
// Purpose : shared definitions for the pipelined bitwise logic unit.
// Contents: op_t  - 3-bit operation select, every code legal
//           apply_op(op, a, b) - one result bit; callers loop it over any width

package logic_pkg;

   typedef enum logic [2:0] {
      OP_AND   = 3'd0,
      OP_OR    = 3'd1,
      OP_XOR   = 3'd2,
      OP_XNOR  = 3'd3,
      OP_NAND  = 3'd4,
      OP_NOR   = 3'd5,
      OP_NOTA  = 3'd6,
      OP_PASSA = 3'd7
   } op_t;

   // Bit-level form keeps the helper width-agnostic; the top applies it per bit.
   function automatic logic apply_op(input op_t op, input logic a, input logic b);
      logic r;
      case (op)
         OP_AND:   r = a & b;
         OP_OR:    r = a | b;
         OP_XOR:   r = a ^ b;
         OP_XNOR:  r = ~(a ^ b);
         OP_NAND:  r = ~(a & b);
         OP_NOR:   r = ~(a | b);
         OP_NOTA:  r = ~a;
         default:  r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/popcount.sv
// rtl/popcount.sv - combinational population count
//
// Purpose : counts the 1 bits of a WIDTH-bit vector.
// Ports   : in  [WIDTH-1:0] - vector to count
//           cnt [CW-1:0]    - number of set bits, CW = $clog2(WIDTH+1)

module popcount #(
   parameter int  WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] in,
   output logic [CW-1:0]    cnt
);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + CW'(in[i]);
      end
   end

endmodule

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - 2-stage valid/ready bitwise logic unit with popcount
//
// Purpose : applies one of eight bitwise ops to a and b, then reports the
//           result, its population count and an all-ones flag.
// Ports   : clk, rst (sync, active-high)
//           in_valid/in_ready, a, b, op  - operand beat
//           out_valid/out_ready, y, ones, all_ones - result beat

module logic_unit_pipe
   import logic_pkg::*;
#(
   parameter int  WIDTH = 8,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic [CW-1:0]    ones,
   output logic             all_ones
);

   logic             v1;
   logic [WIDTH-1:0] y1;
   logic [WIDTH-1:0] f;
   logic [CW-1:0]    cnt1;
   logic             en1;
   logic             en2;

   // A stage may load when it is empty or its contents leave this cycle.
   assign en2      = !out_valid || out_ready;
   assign en1      = !v1 || en2;
   assign in_ready = en1;

   always_comb begin
      f = '0;
      for (int i = 0; i < WIDTH; i++) begin
         f[i] = apply_op(op_t'(op), a[i], b[i]);
      end
   end

   popcount #(.WIDTH(WIDTH)) u_popcount (
      .in  (y1),
      .cnt (cnt1)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         v1        <= 1'b0;
         y1        <= '0;
         out_valid <= 1'b0;
         y         <= '0;
         ones      <= '0;
         all_ones  <= 1'b0;
      end else begin
         if (en1) begin
            v1 <= in_valid;
            if (in_valid) begin
               y1 <= f;
            end
         end
         if (en2) begin
            out_valid <= v1;
            // Data registers only move with a real beat so idle outputs stay put.
            if (v1) begin
               y        <= y1;
               ones     <= cnt1;
               all_ones <= &y1;
            end
         end
      end
   end

endmodule
